// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall controller: controller state encoding
// and the architectural register-address width.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID. x0 never creates a hazard.
module load_use_detector
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_write_addr_reg_i,
  output logic                  hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1_i && (id_rs1_addr_i == ex_write_addr_reg_i);
  assign rs2_hit  = id_uses_rs2_i && (id_rs2_addr_i == ex_write_addr_reg_i);
  assign hazard_o = ex_mem_read_i && (ex_write_addr_reg_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: freezes the pipe on data-memory wait,
// flushes on taken branches, bubbles on load-use, and latches a timeout error.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_write_addr_reg_i,
  input  logic                  em_pc_select_i,
  input  logic                  em_mem_read_i,
  input  logic                  em_mem_write_i,
  input  logic                  dmem_ready_i,
  output logic                  dmem_req_o,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  id_ex_en_o,
  output logic                  ex_mem_en_o,
  output logic                  mem_wb_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
  output logic                  mem_error_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [1:0]            state_o
);

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             err_q, err_d;
  logic             hazard;
  logic             mem_busy;

  load_use_detector u_load_use_detector (
    .id_rs1_addr_i       (id_rs1_addr_i),
    .id_rs2_addr_i       (id_rs2_addr_i),
    .id_uses_rs1_i       (id_uses_rs1_i),
    .id_uses_rs2_i       (id_uses_rs2_i),
    .ex_mem_read_i       (ex_mem_read_i),
    .ex_write_addr_reg_i (ex_write_addr_reg_i),
    .hazard_o            (hazard)
  );

  assign mem_busy = em_mem_read_i | em_mem_write_i;

  // Everything is gated off while reset is held and once in ERROR.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    dmem_req_o     = 1'b0;
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    id_ex_en_o     = 1'b0;
    ex_mem_en_o    = 1'b0;
    mem_wb_en_o    = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (reset_ni && (state_q != ST_ERROR)) begin
      dmem_req_o = mem_busy;
      if (mem_busy && !dmem_ready_i) begin
        if (state_q == ST_RUN) begin
          state_d = ST_MEM_WAIT;
          wait_d  = 8'd1;
        end else if ((wait_q + 8'd1) == TIMEOUT_C) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end else begin
        state_d     = ST_RUN;
        wait_d      = '0;
        pc_en_o     = 1'b1;
        if_id_en_o  = 1'b1;
        id_ex_en_o  = 1'b1;
        ex_mem_en_o = 1'b1;
        mem_wb_en_o = 1'b1;
        if (em_pc_select_i) begin
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
          ex_mem_flush_o = 1'b1;
        end else if (hazard) begin
          pc_en_o       = 1'b0;
          if_id_en_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en_o && (state_q != ST_ERROR) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    err_d = err_q | (state_d == ST_ERROR);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign mem_error_o   = err_q;
  assign stall_count_o = stall_q;
  assign state_o       = state_q;

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8: max consecutive not-ready data-memory cycles before error; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: stall counter width.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 reset_ni  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1_addr_i / id_rs2_addr_i  in  5 each  source registers of instruction in ID.
REQ-006 id_uses_rs1_i / id_uses_rs2_i  in  1 each  ID instruction reads rs1 / rs2.
REQ-007 ex_mem_read_i  in  1  instruction in EX is a load.
REQ-008 ex_write_addr_reg_i  in  5  destination register of instruction in EX.
REQ-009 em_pc_select_i  in  1  EX/MEM register holds a taken branch/jump.
REQ-010 em_mem_read_i / em_mem_write_i  in  1 each  EX/MEM register holds load / store.
REQ-011 dmem_ready_i  in  1  data memory completes access this cycle.
REQ-012 dmem_req_o  out  1  data-memory request.
REQ-013 pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  PC / pipeline-register load enables.
REQ-014 if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  load bubble (zero controls) into register.
REQ-015 mem_error_o  out  1  sticky memory-timeout flag.
REQ-016 stall_count_o  out  CNT_W  cycles with pc_en_o=0, excluding ERROR.
REQ-017 state_o  out  2  current state: RUN=0, MEM_WAIT=1, ERROR=2.

Function
REQ-018 States RUN, MEM_WAIT, ERROR; all outputs combinational from state and inputs except mem_error_o, stall_count_o, state_o (registered).
REQ-019 dmem_req_o = (em_mem_read_i | em_mem_write_i) in RUN and MEM_WAIT; 0 in ERROR.
REQ-020 Per-cycle priority: ERROR > memory stall > branch flush > load-use stall > normal.
REQ-021 Memory stall: dmem_req_o=1 and dmem_ready_i=0 -> all five enables 0, all flushes 0; RUN -> MEM_WAIT at edge, wait counter set to 1.
REQ-022 MEM_WAIT, dmem_ready_i=0: enables 0; if wait counter+1 == MEM_TIMEOUT -> ERROR, else counter increments.
REQ-023 MEM_WAIT, dmem_ready_i=1: cycle evaluated exactly as RUN with access complete (REQ-024/025 apply); -> RUN, counter cleared.
REQ-024 Branch flush: em_pc_select_i=1 -> all enables 1, if_id/id_ex/ex_mem flush 1 for that single cycle; load-use check suppressed.
REQ-025 Load-use: ex_mem_read_i=1, ex_write_addr_reg_i!=0, and matches a used ID source -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, other enables 1; one cycle only (hazard clears as load advances).
REQ-026 Normal cycle: all enables 1, all flushes 0.
REQ-027 ERROR: all enables 0, flushes 0, dmem_req_o=0, mem_error_o=1; exit only by reset.
REQ-028 stall_count_o increments on each edge where pc_en_o=0 and state!=ERROR; saturates at all-ones, never wraps.
REQ-029 Simultaneous memory stall and branch: stall wins; flush applied in the ready cycle if em_pc_select_i still 1 (EX/MEM frozen).
REQ-030 Register x0 destination never causes load-use stall.

Reset
REQ-031 reset_ni=0 asynchronously forces state RUN, wait counter 0, stall_count_o 0, mem_error_o 0.
REQ-032 While reset_ni=0: all enables 0, flushes 0, dmem_req_o 0.
REQ-033 Reset asserted mid MEM_WAIT or ERROR abandons access; first cycle after release is RUN.

Structure
REQ-034 Package pipe_ctrl_pkg holds state enum (2-bit encoding above) and register-address width constant.
REQ-035 Sub-module load_use_detector: purely combinational hazard compare (REQ-025/030); FSM, counters, output muxing in top.

Verification
REQ-036 Load x5 in EX, ID uses rs2=x5 -> one cycle pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; stall_count_o 0->1.
REQ-037 Load writing x0, ID reads x0 -> no stall, all enables 1.
REQ-038 Store in MEM, dmem_ready_i low 3 cycles then high, MEM_TIMEOUT=8 -> enables 0 for 3 cycles, state_o=1 cycles 2-3, RUN after, stall_count_o=3.
REQ-039 MEM_TIMEOUT=4, ready never asserted -> state_o=2 after 4th not-ready edge, mem_error_o=1, dmem_req_o=0, stall_count_o frozen at 4.
REQ-040 em_pc_select_i=1 with load-use also present -> three flushes 1, all enables 1, no load stall.
REQ-041 reset_ni pulsed low asynchronously mid MEM_WAIT -> state_o=0, counters 0 immediately, normal operation after release.
